// File: rtl/expr_pkg.sv
// Shared constants and state encoding for the expression evaluator and recognizer.
package expr_pkg;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;
  localparam logic [7:0] CH_ADD = 8'h2B;
  localparam logic [7:0] CH_MUL = 8'h2A;

  typedef enum logic [1:0] {
    S_DIGIT = 2'd0,
    S_OP    = 2'd1,
    S_ERR   = 2'd2
  } state_t;
endpackage

// File: rtl/char_class.sv
// Combinational character classifier: digit / '+' / '*' / anything else.
module char_class
  import expr_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_add,
  output logic       is_mul,
  output logic       is_bad
);
  // ASCII '0'..'9' carry their value in the low nibble, so no subtract is needed.
  always_comb begin
    is_digit = (in >= CH_0) && (in <= CH_9);
    digit    = in[3:0];
    is_add   = (in == CH_ADD);
    is_mul   = (in == CH_MUL);
    is_bad   = !(is_digit || is_add || is_mul);
  end
endmodule

// File: rtl/expr_eval.sv
// Streaming evaluator for single-digit '+'/'*' expressions, '*' binding tighter.
module expr_eval
  import expr_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [7:0]   in,
  input  logic         in_valid,
  output logic         ok,
  output logic [W-1:0] result,
  output logic         err,
  output logic         ovf
);
  logic         is_digit, is_add, is_mul, is_bad;
  logic [3:0]   digit;

  state_t       state_q, state_d;
  logic [W-1:0] sum_q, sum_d, term_q, term_d, result_q, result_d;
  logic         pend_q, pend_d, ok_q, ok_d, err_q, err_d, ovf_q, ovf_d;

  logic [2*W-1:0] prod;
  logic [W:0]     add_full;
  logic [W-1:0]   term_nx;

  char_class u_cc (
    .in       (in),
    .is_digit (is_digit),
    .digit    (digit),
    .is_add   (is_add),
    .is_mul   (is_mul),
    .is_bad   (is_bad)
  );

  // Full-precision product and sum so the overflow test sees the lost bits.
  always_comb begin
    prod     = {{W{1'b0}}, term_q} * {{(2*W-4){1'b0}}, digit};
    add_full = {1'b0, sum_q} + {1'b0, term_q};
    term_nx  = pend_q ? prod[W-1:0] : {{(W-4){1'b0}}, digit};
  end

  // Next-state, accumulator and flag logic for one accepted character.
  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    term_d   = term_q;
    pend_d   = pend_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    if (in_valid) begin
      case (state_q)
        S_DIGIT: begin
          if (is_digit) begin
            term_d   = term_nx;
            result_d = sum_q + term_nx;
            state_d  = S_OP;
            if (pend_q && (|prod[2*W-1:W])) ovf_d = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
        S_OP: begin
          if (is_add) begin
            sum_d   = add_full[W-1:0];
            pend_d  = 1'b0;
            state_d = S_DIGIT;
            if (add_full[W]) ovf_d = 1'b1;
          end else if (is_mul) begin
            pend_d  = 1'b1;
            state_d = S_DIGIT;
          end else if (is_digit || is_bad) begin
            state_d = S_ERR;
          end
        end
        default: state_d = S_ERR;
      endcase
    end
    ok_d  = (state_d == S_OP);
    err_d = (state_d == S_ERR);
  end

  // State and registered outputs; clr also serves as the per-expression restart.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_DIGIT;
      sum_q    <= '0;
      term_q   <= '0;
      pend_q   <= 1'b0;
      result_q <= '0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      term_q   <= term_d;
      pend_q   <= pend_d;
      result_q <= result_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ok     = ok_q;
  assign err    = err_q;
  assign ovf    = ovf_q;
  assign result = result_q;
endmodule

// File: tb/tb_expr_eval.sv
`timescale 1ns/1ps
module tb_expr_eval;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  in_c = 8'h00;
  logic        in_valid = 1'b0;

  logic        ok16, err16, ovf16;
  logic [15:0] res16;
  logic        ok8, err8, ovf8;
  logic [7:0]  res8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  expr_eval #(.W(16)) dut16 (
    .clk(clk), .clr(clr), .in(in_c), .in_valid(in_valid),
    .ok(ok16), .result(res16), .err(err16), .ovf(ovf16)
  );

  expr_eval #(.W(8)) dut8 (
    .clk(clk), .clr(clr), .in(in_c), .in_valid(in_valid),
    .ok(ok8), .result(res8), .err(err8), .ovf(ovf8)
  );

  // Present one character for exactly one rising edge; sample 1ns after it.
  task automatic send(input logic [7:0] c);
    in_c = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Asynchronous clear pulse placed between edges.
  task automatic do_clr();
    clr = 1'b1;
    #2;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (ok16 !== 1'b0) begin n_bad++; $display("FAIL reset_ok got %b want 0", ok16); end
    n_cmp++; if (err16 !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err16); end
    n_cmp++; if (ovf16 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf16); end
    n_cmp++; if (res16 !== 16'd0) begin n_bad++; $display("FAIL reset_result got %0d want 0", res16); end
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0]  s  [5] = '{"1", "+", "3", "*", "9"};
    logic [15:0] er [5] = '{16'd1, 16'd1, 16'd4, 16'd4, 16'd28};
    logic        eo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      send(s[i]);
      n_cmp++; if (res16 !== er[i]) begin n_bad++; $display("FAIL basic_result[%0d] got %0d want %0d", i, res16, er[i]); end
      n_cmp++; if (ok16 !== eo[i]) begin n_bad++; $display("FAIL basic_ok[%0d] got %b want %b", i, ok16, eo[i]); end
      n_cmp++; if (err16 !== 1'b0) begin n_bad++; $display("FAIL basic_err[%0d] got %b want 0", i, err16); end
    end
  endtask

  task automatic test_mixed();
    logic [7:0]  s  [7] = '{"1", "*", "9", "+", "8", "+", "0"};
    logic [15:0] er [7] = '{16'd1, 16'd1, 16'd9, 16'd9, 16'd17, 16'd17, 16'd17};
    logic        eo [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_clr();
    for (int i = 0; i < 7; i++) begin
      send(s[i]);
      n_cmp++; if (res16 !== er[i]) begin n_bad++; $display("FAIL mixed_result[%0d] got %0d want %0d", i, res16, er[i]); end
      n_cmp++; if (ok16 !== eo[i]) begin n_bad++; $display("FAIL mixed_ok[%0d] got %b want %b", i, ok16, eo[i]); end
    end
  endtask

  task automatic test_held();
    do_clr();
    in_c = "9";
    in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ok16 !== 1'b1 || res16 !== 16'd9) begin n_bad++; $display("FAIL held_e1 got ok=%b res=%0d want ok=1 res=9", ok16, res16); end
    @(posedge clk); #1;
    n_cmp++; if (err16 !== 1'b1 || ok16 !== 1'b0) begin n_bad++; $display("FAIL held_e2 got err=%b ok=%b want err=1 ok=0", err16, ok16); end
    n_cmp++; if (res16 !== 16'd9) begin n_bad++; $display("FAIL held_e2_result got %0d want 9", res16); end
    in_c = "+";
    @(posedge clk); #1;
    in_c = "1";
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (err16 !== 1'b1 || ok16 !== 1'b0 || res16 !== 16'd9) begin n_bad++; $display("FAIL held_absorb got err=%b ok=%b res=%0d want err=1 ok=0 res=9", err16, ok16, res16); end
  endtask

  task automatic test_errors();
    do_clr();
    send("*");
    n_cmp++; if (err16 !== 1'b1) begin n_bad++; $display("FAIL lead_mul_err got %b want 1", err16); end
    send("1");
    n_cmp++; if (err16 !== 1'b1 || ok16 !== 1'b0) begin n_bad++; $display("FAIL lead_mul_sticky got err=%b ok=%b want err=1 ok=0", err16, ok16); end
    do_clr();
    send("1"); send("+"); send("a");
    n_cmp++; if (err16 !== 1'b1 || res16 !== 16'd1) begin n_bad++; $display("FAIL bad_char_err got err=%b res=%0d want err=1 res=1", err16, res16); end
    // mid-cycle asynchronous clear
    #3;
    clr = 1'b1;
    #1;
    n_cmp++; if (err16 !== 1'b0 || ok16 !== 1'b0 || res16 !== 16'd0 || ovf16 !== 1'b0)
      begin n_bad++; $display("FAIL async_clr got err=%b ok=%b res=%0d ovf=%b want all 0", err16, ok16, res16, ovf16); end
    // clr wins over a valid byte at the edge
    in_c = "7";
    in_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ok16 !== 1'b0 || res16 !== 16'd0) begin n_bad++; $display("FAIL clr_wins got ok=%b res=%0d want ok=0 res=0", ok16, res16); end
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (ok16 !== 1'b1 || res16 !== 16'd7) begin n_bad++; $display("FAIL first_after_clr got ok=%b res=%0d want ok=1 res=7", ok16, res16); end
  endtask

  task automatic test_overflow();
    do_clr();
    send("9"); send("*"); send("9");
    n_cmp++; if (ovf8 !== 1'b0 || res8 !== 8'd81) begin n_bad++; $display("FAIL ovf8_81 got ovf=%b res=%0d want ovf=0 res=81", ovf8, res8); end
    send("*"); send("9");
    n_cmp++; if (res8 !== 8'd217 || ok8 !== 1'b1 || ovf8 !== 1'b1) begin n_bad++; $display("FAIL ovf8_729 got res=%0d ok=%b ovf=%b want res=217 ok=1 ovf=1", res8, ok8, ovf8); end
    n_cmp++; if (res16 !== 16'd729 || ovf16 !== 1'b0) begin n_bad++; $display("FAIL ovf16_729 got res=%0d ovf=%b want res=729 ovf=0", res16, ovf16); end
    send("+"); send("1");
    n_cmp++; if (res8 !== 8'd218 || ovf8 !== 1'b1) begin n_bad++; $display("FAIL ovf8_plus1 got res=%0d ovf=%b want res=218 ovf=1", res8, ovf8); end
    // sum overflow: 200 + 100 at W=8 (200 = 8*5*5, 100 = 4*5*5)
    do_clr();
    send("8"); send("*"); send("5"); send("*"); send("5"); send("+");
    n_cmp++; if (ovf8 !== 1'b0) begin n_bad++; $display("FAIL ovf8_200 got ovf=%b want 0", ovf8); end
    send("4"); send("*"); send("5"); send("*"); send("5"); send("+");
    n_cmp++; if (ovf8 !== 1'b1) begin n_bad++; $display("FAIL ovf8_sum got ovf=%b want 1", ovf8); end
    send("a");
    n_cmp++; if (ovf8 !== 1'b1 || err8 !== 1'b1) begin n_bad++; $display("FAIL ovf8_err_keep got ovf=%b err=%b want 1 1", ovf8, err8); end
  endtask

  task automatic test_idle();
    logic [7:0]  s  [5] = '{"2", "*", "3", "+", "4"};
    logic [15:0] er [5] = '{16'd2, 16'd2, 16'd6, 16'd6, 16'd10};
    logic        eo [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_clr();
    for (int i = 0; i < 5; i++) begin
      send(s[i]);
      in_c = "5";
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (res16 !== er[i] || ok16 !== eo[i] || err16 !== 1'b0)
        begin n_bad++; $display("FAIL idle[%0d] got res=%0d ok=%b err=%b want res=%0d ok=%b err=0", i, res16, ok16, err16, er[i], eo[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_held();
    test_errors();
    test_overflow();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/expr_eval.md
# expr_eval

Streaming evaluator for single-digit arithmetic expressions over `+` and `*`. It sits directly downstream of the character-stream expression recognizer and consumes the same ASCII byte stream, one character per accepted cycle. It produces the running numeric value with `*` binding tighter than `+`, plus validity, error and overflow flags. A clear restarts evaluation for the next expression.

## Interface
Parameters:
- `W`, default 16: result width; all arithmetic is modulo 2^W.

Ports:
- `clk` in 1: single clock, rising-edge.
- `clr` in 1: reset, asynchronous, active-high; also the per-expression restart.
- `in` in 8: ASCII character.
- `in_valid` in 1: `in` is consumed on a rising edge only when high.
- `ok` out 1: the accepted stream so far is a well-formed expression ending in a digit.
- `result` out W: value of the expression accepted so far.
- `err` out 1: sticky syntax error.
- `ovf` out 1: sticky; some add or multiply exceeded 2^W-1.

## Operation
- Character classes:
  - digit is `"0"`–`"9"` (value = in − 8'h30);
  - `ADD` is `"+"`;
  - `MUL` is `"*"`;
  - any other byte is illegal.
- Internal registers:
  - `sum` (W bits): committed sum of finished terms.
  - `term` (W bits): current product term.
  - `pend_mul` (1 bit): last operator was `*`.
  - `state`.
- States and transitions:
  - `S_DIGIT`, expecting a digit; the reset state.
    - Digit d: `term` ← (pend_mul ? term·d : d); → `S_OP`.
    - Anything else: → `S_ERR`.
  - `S_OP`, expecting an operator.
    - `+`: `sum` ← sum+term, `pend_mul` ← 0; → `S_DIGIT`.
    - `*`: `pend_mul` ← 1; → `S_DIGIT`.
    - Digit or illegal byte: → `S_ERR`.
  - `S_ERR`: absorbing; every byte is ignored until `clr`.
- Outputs, all registered:
  - `ok` = (state == `S_OP`).
  - `err` = (state == `S_ERR`).
  - `result` is updated only on a transition into `S_OP`, to sum + new term (mod 2^W). It holds its value in every other case, including after an operator, in `S_ERR`, and while `in_valid` = 0.
- `ovf`: set when term·d ≥ 2^W or sum+term ≥ 2^W, evaluated at full precision (2W bits for the product). Once set, it stays set until `clr`. Entering `S_ERR` does not clear it.
- Multi-digit numbers are not supported; two consecutive digits are an error.

## Timing
- Reset (`clr` = 1, takes effect immediately):
  - `ok` = 0, `err` = 0, `ovf` = 0, `result` = 0;
  - `sum` = 0, `term` = 0, `pend_mul` = 0;
  - state `S_DIGIT`.
- Latency: one cycle. A character accepted at edge N is reflected on all outputs after edge N.
- `in_valid` = 0: no register changes.
- `in_valid` = 1 with the same byte held for k cycles counts as k characters. Held digits therefore produce an error.
- `clr` asserted while `in_valid` = 1: `clr` wins, and the byte is discarded.
- The first accepted edge after `clr` deasserts processes the byte present at that edge.
- `term` and `sum` wrap modulo 2^W.
- `result` equals the true value mod 2^W whenever `ok` = 1.

## Structure
- Shared package `expr_pkg`:
  - ASCII constants `CH_0`, `CH_9`, `CH_ADD`, `CH_MUL`;
  - state enum `S_DIGIT`/`S_OP`/`S_ERR`, 2-bit encoding.
- Sub-module `char_class`: combinational decode of `in` into `is_digit`, `digit[3:0]`, `is_add`, `is_mul`, `is_bad`. The recognizer may reuse it.
- The top level holds the FSM, the accumulators, and the overflow detection.

## Test plan
- `"1","+","3","*","9"`, one per cycle with `in_valid` = 1:
  - `result` goes 1, 1, 4, 4, 28;
  - `ok` goes 1, 0, 1, 0, 1;
  - `err` = 0 throughout.
- `clr` pulse, then `"1","*","9","+","8"`: `result` goes 1, 1, 9, 9, 17 with `ok` = 1. Then `"+"`: `ok` = 0, `result` holds 17. Then `"0"`: `ok` = 1, `result` = 17.
- `"9"` held for 3 cycles with `in_valid` = 1:
  - after edge 1: `ok` = 1, `result` = 9;
  - after edge 2: `err` = 1, `ok` = 0, `result` still 9;
  - later bytes ignored until `clr`.
- Leading `"*"`, or `"a"` at any point: `err` = 1 on the next edge and stays set. Asserting `clr` mid-cycle clears all outputs to 0 immediately, without waiting for a clock.
- `W` = 8, `"9","*","9","*","9"`:
  - `result` = 729 mod 256 = 217, `ok` = 1, `ovf` = 1;
  - then `"+","1"`: `result` = 218, `ovf` stays 1.
- `in_valid` toggled 0/1 between the characters of `"2*3+4"`: `result` = 10, `ok` = 1. Idle cycles leave all outputs unchanged.
